// File: rtl/cpu_pkg.sv
// Shared types, ALU opcode values and instruction field positions for multicycle_cpu.
// Field positions are functions so one package serves every REG_BITS/DATA_WIDTH combination.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        IT_NOP   = 2'd0,
        IT_ALU   = 2'd1,
        IT_LOAD  = 2'd2,
        IT_STORE = 2'd3
    } itype_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;

    localparam int OPCODE_BITS = 4;
    localparam int TYPE_BITS   = 2;

    function automatic int instr_width(input int reg_bits, input int data_width);
        return TYPE_BITS + 3 * reg_bits + data_width + OPCODE_BITS;
    endfunction

    function automatic int offset_lsb();
        return OPCODE_BITS;
    endfunction

    function automatic int rs2_lsb(input int data_width);
        return data_width + OPCODE_BITS;
    endfunction

    function automatic int rs1_lsb(input int reg_bits, input int data_width);
        return reg_bits + data_width + OPCODE_BITS;
    endfunction

    function automatic int rd_lsb(input int reg_bits, input int data_width);
        return 2 * reg_bits + data_width + OPCODE_BITS;
    endfunction

    function automatic int type_lsb(input int reg_bits, input int data_width);
        return 3 * reg_bits + data_width + OPCODE_BITS;
    endfunction

endpackage

// File: rtl/cpu_data_mem.sv
// Private data memory of multicycle_cpu: synchronous write, registered read.
// Contents are deliberately not reset.
module cpu_data_mem #(
    parameter int ADDR_BITS  = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [2**ADDR_BITS];

    // Write port and registered read port (read returns pre-write data)
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle core: IDLE/DECODE/EXECUTE/MEM/WRITEBACK sequencing of one instruction at a time.
// Define CPU_DEBUG_PORT_EN to add the combinational dbg_addr/dbg_data register read port.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int ADDR_BITS   = 5,
    parameter  int NUM_REGS    = 4,
    localparam int REG_BITS    = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = instr_width(REG_BITS, DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   done,
    output logic                   illegal
`ifdef CPU_DEBUG_PORT_EN
    ,
    input  logic [REG_BITS-1:0]    dbg_addr,
    output logic [DATA_WIDTH-1:0]  dbg_data
`endif
);

    localparam int TYPE_LSB   = type_lsb(REG_BITS, DATA_WIDTH);
    localparam int RD_LSB     = rd_lsb(REG_BITS, DATA_WIDTH);
    localparam int RS1_LSB    = rs1_lsb(REG_BITS, DATA_WIDTH);
    localparam int RS2_LSB    = rs2_lsb(DATA_WIDTH);
    localparam int OFFSET_LSB = offset_lsb();

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic [DATA_WIDTH-1:0]  regs_r [NUM_REGS];
    logic [DATA_WIDTH-1:0]  a_r;
    logic [DATA_WIDTH-1:0]  b_r;
    logic [DATA_WIDTH-1:0]  d_r;
    logic [DATA_WIDTH-1:0]  alu_r;
    logic                   done_r;
    logic                   illegal_r;

    itype_t                 itype_s;
    logic [REG_BITS-1:0]    rd_s;
    logic [REG_BITS-1:0]    rs1_s;
    logic [REG_BITS-1:0]    rs2_s;
    logic [DATA_WIDTH-1:0]  offset_s;
    logic [3:0]             opcode_s;
    logic                   illegal_op_s;
    logic [3:0]             alu_op_s;
    logic [DATA_WIDTH-1:0]  alu_b_s;
    logic [DATA_WIDTH-1:0]  shamt_s;
    logic [DATA_WIDTH-1:0]  alu_s;
    logic                   retire_s;
    logic                   mem_we_s;
    logic [ADDR_BITS-1:0]   mem_addr_s;
    logic [DATA_WIDTH-1:0]  mem_rdata_s;

    assign itype_s      = itype_t'(instr_r[TYPE_LSB +: 2]);
    assign rd_s         = instr_r[RD_LSB +: REG_BITS];
    assign rs1_s        = instr_r[RS1_LSB +: REG_BITS];
    assign rs2_s        = instr_r[RS2_LSB +: REG_BITS];
    assign offset_s     = instr_r[OFFSET_LSB +: DATA_WIDTH];
    assign opcode_s     = instr_r[3:0];
    assign illegal_op_s = (itype_s == IT_ALU) && opcode_s[3];

    assign instr_ready = (state_r == ST_IDLE);
    assign done        = done_r;
    assign illegal     = illegal_r;

    // Memory accesses always address low bits of the ALU sum; writes are dropped on reset
    assign mem_addr_s = alu_r[ADDR_BITS-1:0];
    assign mem_we_s   = (state_r == ST_MEM) && (itype_s == IT_STORE) && !rst;

    // ALU; LOAD/STORE reuse it as an address adder with the offset as operand B
    always_comb begin
        alu_op_s = OP_ADD;
        alu_b_s  = offset_s;
        if (itype_s == IT_ALU) begin
            alu_op_s = opcode_s;
            alu_b_s  = b_r;
        end else begin
            alu_op_s = OP_ADD;
            alu_b_s  = offset_s;
        end
        shamt_s = DATA_WIDTH'(32'(alu_b_s) % 32'(DATA_WIDTH));
        alu_s   = {DATA_WIDTH{1'b0}};
        case (alu_op_s)
            OP_ADD:  alu_s = a_r + alu_b_s;
            OP_SUB:  alu_s = a_r - alu_b_s;
            OP_AND:  alu_s = a_r & alu_b_s;
            OP_OR:   alu_s = a_r | alu_b_s;
            OP_XOR:  alu_s = a_r ^ alu_b_s;
            OP_SLL:  alu_s = a_r << shamt_s;
            OP_SRL:  alu_s = a_r >> shamt_s;
            OP_PASS: alu_s = alu_b_s;
            default: alu_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Next-state and retirement decode
    always_comb begin
        state_nx_s = state_r;
        retire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (itype_s == IT_NOP) begin
                    state_nx_s = ST_IDLE;
                    retire_s   = 1'b1;
                end else begin
                    state_nx_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (itype_s == IT_ALU) begin
                    state_nx_s = ST_WRITEBACK;
                end else begin
                    state_nx_s = ST_MEM;
                end
            end
            ST_MEM: begin
                if (itype_s == IT_LOAD) begin
                    state_nx_s = ST_WRITEBACK;
                end else begin
                    state_nx_s = ST_IDLE;
                    retire_s   = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                state_nx_s = ST_IDLE;
                retire_s   = 1'b1;
            end
            default: begin
                state_nx_s = ST_IDLE;
                retire_s   = 1'b0;
            end
        endcase
    end

    // State register and registered completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            done_r    <= retire_s;
            illegal_r <= retire_s && (state_r == ST_WRITEBACK) && illegal_op_s;
        end
    end

    // Instruction latch at acceptance, operand capture in DECODE, ALU result in EXECUTE
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r <= {INSTR_WIDTH{1'b0}};
            a_r     <= {DATA_WIDTH{1'b0}};
            b_r     <= {DATA_WIDTH{1'b0}};
            d_r     <= {DATA_WIDTH{1'b0}};
            alu_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && instr_valid) begin
                instr_r <= instr;
            end
            if (state_r == ST_DECODE) begin
                a_r <= regs_r[rs1_s];
                b_r <= regs_r[rs2_s];
                d_r <= regs_r[rd_s];
            end
            if (state_r == ST_EXECUTE) begin
                alu_r <= alu_s;
            end
        end
    end

    // Register file: reset to r[i] = i, single write port at the WRITEBACK edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= DATA_WIDTH'(i);
            end
        end else if (state_r == ST_WRITEBACK) begin
            if (itype_s == IT_LOAD) begin
                regs_r[rd_s] <= mem_rdata_s;
            end else if (!illegal_op_s) begin
                regs_r[rd_s] <= alu_r;
            end
        end
    end

    cpu_data_mem #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_data_mem (
        .clk  (clk),
        .we   (mem_we_s),
        .addr (mem_addr_s),
        .wdata(d_r),
        .rdata(mem_rdata_s)
    );

`ifdef CPU_DEBUG_PORT_EN
    assign dbg_data = regs_r[dbg_addr];
`endif

endmodule
